// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the program ROM address from pc, latches the returned
// word into an instruction register and hands it to execute over valid/ready.
// Handles jump redirects, halt on jump-to-self and a saturating retire count.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 35,
  parameter int RET_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_go,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  input  logic               i_jump_taken,
  input  logic [ADDR_W-1:0]  i_jump_addr,
  output logic               o_halted,
  output logic [RET_W-1:0]   o_retired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               r_halted;
  logic [RET_W-1:0]   r_retired;

  logic w_xfer;
  logic w_load;
  logic w_ret_max;

  // Handshake and fetch-enable decode
  always_comb begin
    w_xfer    = r_valid && i_instr_ready;
    w_load    = !r_valid || w_xfer;
    w_ret_max = (r_retired == {RET_W{1'b1}});
  end

  // Control FSM, pc, instruction register and retire counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= '0;
    end else begin
      // Every consumed instruction retires, including a halting jump.
      if (w_xfer && !w_ret_max)
        r_retired <= r_retired + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_go)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_xfer && i_jump_taken) begin
            // Drop the sequential word; target is fetched next cycle.
            r_pc    <= i_jump_addr;
            r_valid <= 1'b0;
            if (i_jump_addr == r_instr_pc) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end else if (w_load) begin
            r_instr    <= i_rom_data;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 1'b1;
          end
        end
        S_HALT: begin
          if (i_go) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr    = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_halted      = r_halted;
  assign o_retired     = r_retired;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage between the program counter and the 8-bit-address, 35-bit-wide asynchronous program ROM.
- Drives the ROM address, latches the returned word into an instruction register, and presents it to the execute stage over a valid/ready handshake.
- Accepts jump redirects from the execute stage and detects a halt (jump-to-self).
- Keeps a retired-instruction counter.

Parameters:
- ADDR_W, 8, program address width (ROM depth 2^ADDR_W).
- INSTR_W, 35, instruction word width.
- RET_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start/restart pulse; leaves IDLE or HALT.
- rom_addr  out  ADDR_W  address to program ROM; equals pc combinationally.
- rom_data  in  INSTR_W  instruction returned by the ROM in the same cycle (asynchronous).
- instr  out  INSTR_W  instruction register contents.
- instr_pc  out  ADDR_W  address the current instr was fetched from.
- instr_valid  out  1  instr holds an unconsumed instruction.
- instr_ready  in  1  execute stage accepts instr this cycle.
- jump_taken  in  1  execute redirect; only sampled when instr_valid && instr_ready.
- jump_addr  in  ADDR_W  redirect target.
- halted  out  1  high in HALT state.
- retired  out  RET_W  count of consumed instructions.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, retired=0.
- Reset has priority over every other input.
- Reset mid-operation discards the instruction in flight; no retire is counted for that cycle.
- transfer = instr_valid && instr_ready.
- States:
  - IDLE: no fetch; instr_valid stays 0. go → RUN; pc keeps its value (0 after reset).
  - RUN: fetch/issue as below.
  - HALT: halted=1, instr_valid=0, pc frozen. go → RUN, resuming fetch at pc.
- RUN fetch rule (load condition = !instr_valid || transfer):
  - If the load condition holds and no redirect: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - pc wraps modulo 2^ADDR_W (255+1 → 0); no error on wrap.
  - If instr_valid && !instr_ready: hold instr, instr_pc and pc unchanged (stall).
- Redirect, on transfer && jump_taken:
  - If jump_addr == instr_pc: state → HALT, instr_valid<=0, pc<=jump_addr, retired still increments.
  - Otherwise: pc<=jump_addr, instr_valid<=0 (the sequentially fetched word is not loaded).
  - The next cycle fetches from jump_addr; the target becomes valid 2 cycles after the jumping instruction's transfer edge, giving exactly 1 bubble.
- jump_taken without transfer is ignored.
- Throughput: with instr_ready held high and no jumps, one instruction per cycle; first instr_valid appears 1 cycle after entering RUN.
- retired increments by 1 on every transfer and saturates at 2^RET_W-1 (no wrap).
- go while in RUN is ignored.
- NOP (all-zero word) is not special; it is fetched and retired like any instruction.
- All outputs except rom_addr are registered.

Test Plan:
- Reset, go, instr_ready=1, ROM word[n]=n, no jumps → instr_pc sequence 0,1,2,… one per cycle, first valid 1 cycle after go; retired=k after k transfers.
- Hold instr_ready=0 for 3 cycles at instr_pc=4 → instr, instr_pc=4 and rom_addr=5 stable; on release instr_pc=5 the next cycle; retired unaffected during the stall.
- Transfer at instr_pc=16 with jump_taken=1, jump_addr=13 → instr_valid=0 for one cycle, then instr_pc=13; address 17 never appears on instr_pc.
- Transfer at instr_pc=20 with jump_taken=1, jump_addr=20 → halted=1, instr_valid=0, retired incremented, rom_addr frozen at 20; go → RUN and instr_pc=20 re-issued.
- Run sequentially from pc=254 → instr_pc 254,255,0,1 with no glitch in instr_valid.
- Assert reset while instr_valid=1 at instr_pc=9 → next cycle all outputs at reset values, state IDLE; nothing issues until go. Separately, force retired=0xFFFE and perform 3 transfers → retired=0xFFFF.
